// File: rtl/intc_ng.sv
// Interrupt controller: per-pin synchroniser, level/edge qualification with polarity,
// pending latch with write-1-to-clear, enable mask and a registered aggregate irq.
module intc_ng #(
    parameter logic [4:0]  BASE_ADDR   = 5'h1c,
    parameter int          NUM_INTS    = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] DFL_IE      = 16'h0,
    parameter logic [15:0] DFL_TYPE    = 16'h0,
    parameter logic [15:0] DFL_POL     = 16'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic [NUM_INTS-1:0] int_in,
    output logic                irq
);

    localparam int          NB      = (NUM_INTS + 7) / 8;
    localparam logic [2:0]  NB3     = 3'(NB);
    localparam logic [2:0]  ARM_MAX = 3'(SYNC_STAGES + 1);
    localparam logic [15:0] CH_MASK = 16'((32'd1 << NUM_INTS) - 32'd1);

    logic [NUM_INTS-1:0] r_sync [SYNC_STAGES];
    logic [NUM_INTS-1:0] r_prev;
    logic [NUM_INTS-1:0] r_ie;
    logic [NUM_INTS-1:0] r_ip;
    logic [NUM_INTS-1:0] r_type;
    logic [NUM_INTS-1:0] r_pol;
    logic [2:0]          r_arm_cnt;
    logic                r_irq;

    logic [4:0]          w_off;
    logic                w_dec;
    logic [15:0]         w_bmask;
    logic [15:0]         w_wsel;
    logic [15:0]         w_di16;
    logic [15:0]         w_rsel;
    logic [NUM_INTS-1:0] w_we_ie;
    logic [NUM_INTS-1:0] w_we_ip;
    logic [NUM_INTS-1:0] w_we_type;
    logic [NUM_INTS-1:0] w_we_pol;
    logic [NUM_INTS-1:0] w_w1c;
    logic [NUM_INTS-1:0] w_cur;
    logic [NUM_INTS-1:0] w_act;
    logic [NUM_INTS-1:0] w_edge;
    logic [NUM_INTS-1:0] w_set;
    logic                w_armed;

    // Decode is modular on the 5-bit bus: offset from BASE_ADDR picks bank and register.
    assign w_off   = csr_a - BASE_ADDR;
    assign w_dec   = (w_off[4:2] < NB3);
    assign w_bmask = w_off[2] ? 16'hFF00 : 16'h00FF;
    assign w_wsel  = (csr_we && w_dec) ? (w_bmask & CH_MASK) : 16'h0000;
    assign w_di16  = {csr_di, csr_di};

    assign w_we_ie   = (w_off[1:0] == 2'd0) ? w_wsel[NUM_INTS-1:0] : '0;
    assign w_we_ip   = (w_off[1:0] == 2'd1) ? w_wsel[NUM_INTS-1:0] : '0;
    assign w_we_type = (w_off[1:0] == 2'd2) ? w_wsel[NUM_INTS-1:0] : '0;
    assign w_we_pol  = (w_off[1:0] == 2'd3) ? w_wsel[NUM_INTS-1:0] : '0;
    assign w_w1c     = w_we_ip & w_di16[NUM_INTS-1:0];

    always_comb begin
        w_rsel = 16'h0000;
        case (w_off[1:0])
            2'd0:    w_rsel = 16'(r_ie);
            2'd1:    w_rsel = 16'(r_ip);
            2'd2:    w_rsel = 16'(r_type);
            default: w_rsel = 16'(r_pol);
        endcase
        csr_do = 8'h00;
        if (w_dec)
            csr_do = w_off[2] ? w_rsel[15:8] : w_rsel[7:0];
    end

    // Edge terms look only at cur/prev, so a POL write alone can never fake an edge.
    assign w_cur   = r_sync[SYNC_STAGES-1];
    assign w_act   = w_cur ~^ r_pol;
    assign w_edge  = (r_pol & w_cur & ~r_prev) | (~r_pol & ~w_cur & r_prev);
    assign w_armed = (r_arm_cnt == ARM_MAX);
    assign w_set   = (r_type & w_edge & {NUM_INTS{w_armed}}) | (~r_type & w_act);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                r_sync[s] <= '0;
            r_prev    <= '0;
            r_arm_cnt <= 3'd0;
        end else begin
            r_sync[0] <= int_in;
            for (int s = 1; s < SYNC_STAGES; s++)
                r_sync[s] <= r_sync[s-1];
            r_prev <= w_cur;
            if (!w_armed)
                r_arm_cnt <= r_arm_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ie   <= DFL_IE[NUM_INTS-1:0];
            r_type <= DFL_TYPE[NUM_INTS-1:0];
            r_pol  <= DFL_POL[NUM_INTS-1:0];
            r_ip   <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_ie   <= (r_ie   & ~w_we_ie)   | (w_di16[NUM_INTS-1:0] & w_we_ie);
            r_type <= (r_type & ~w_we_type) | (w_di16[NUM_INTS-1:0] & w_we_type);
            r_pol  <= (r_pol  & ~w_we_pol)  | (w_di16[NUM_INTS-1:0] & w_we_pol);
            r_ip   <= w_set | (r_ip & ~w_w1c);
            r_irq  <= |(r_ip & r_ie);
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_intc_ng.sv
// Directed bench for intc_ng: a 12-channel instance for register/qualification behaviour and
// an 8-channel all-edge/rising instance for arming and asynchronous reset.
module tb_intc_ng;

    logic        clk;
    logic        rst_n;
    logic        rst2_n;
    logic [4:0]  csr_a;
    logic [7:0]  csr_di;
    logic        csr_we;
    logic        csr_we2;
    logic [7:0]  csr_do;
    logic [7:0]  csr_do2;
    logic [11:0] int_in;
    logic [7:0]  int2;
    logic        irq;
    logic        irq2;

    int n_tests = 0;
    int n_fail  = 0;

    intc_ng #(
        .BASE_ADDR(5'h10), .NUM_INTS(12), .SYNC_STAGES(2),
        .DFL_IE(16'h0003), .DFL_TYPE(16'h0000), .DFL_POL(16'h0000)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(csr_do), .int_in(int_in), .irq(irq)
    );

    intc_ng #(
        .BASE_ADDR(5'h00), .NUM_INTS(8), .SYNC_STAGES(2),
        .DFL_IE(16'h0000), .DFL_TYPE(16'hFFFF), .DFL_POL(16'hFFFF)
    ) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we2),
        .csr_do(csr_do2), .int_in(int2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_a = a; csr_di = d; csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic wr2(input logic [4:0] a, input logic [7:0] d);
        csr_a = a; csr_di = d; csr_we2 = 1'b1;
        tick();
        csr_we2 = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
        csr_a = a;
        #1;
        chk(tag, 16'(csr_do), 16'(exp));
    endtask

    task automatic chk_rd2(input string tag, input logic [4:0] a, input logic [7:0] exp);
        csr_a = a;
        #1;
        chk(tag, 16'(csr_do2), 16'(exp));
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        csr_a = 5'h00; csr_di = 8'h00; csr_we = 1'b0; csr_we2 = 1'b0;
        int_in = 12'hFFF; int2 = 8'hFF;
        tick(2);

        // Reset defaults (held in reset so the sync transient is not yet seen)
        chk_rd("rst_ie0", 5'h10, 8'h03);
        chk_rd("rst_ie1", 5'h14, 8'h00);
        chk_rd("rst_ip1", 5'h15, 8'h00);
        chk_rd("rst_pol0", 5'h13, 8'h00);
        chk_rd("rst_pol1", 5'h17, 8'h00);
        chk_rd("rst_undec", 5'h18, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_irq", 16'(irq), 16'h0);
        end

        // Release: sync flops start at 0, which active-low level channels see as active
        rst_n = 1'b1; rst2_n = 1'b1;
        tick(4);
        chk_rd("post_rel_ip0", 5'h11, 8'hFF);
        chk_rd("post_rel_ip1", 5'h15, 8'h0F);
        wr(5'h11, 8'hFF);
        wr(5'h15, 8'hFF);
        tick();
        chk_rd("clr_ip0", 5'h11, 8'h00);
        chk_rd("clr_ip1", 5'h15, 8'h00);
        chk("clr_irq", 16'(irq), 16'h0);

        // Falling edge on channel 0
        wr(5'h12, 8'h01);
        int_in[0] = 1'b0;
        tick(2);
        chk_rd("edge_ip_e1", 5'h11, 8'h00);
        tick();
        chk_rd("edge_ip_e2", 5'h11, 8'h01);
        chk("edge_irq_e2", 16'(irq), 16'h0);
        tick();
        chk("edge_irq_e3", 16'(irq), 16'h1);
        wr(5'h11, 8'h01);
        chk_rd("edge_w1c_ip", 5'h11, 8'h00);
        tick();
        chk("edge_w1c_irq", 16'(irq), 16'h0);
        tick(4);
        chk_rd("edge_noretrig", 5'h11, 8'h00);
        int_in[0] = 1'b1;
        tick(4);
        chk_rd("edge_rise_ign", 5'h11, 8'h00);

        // Level, active-high, channel 9 cleared while still active
        wr(5'h17, 8'h02);
        wr(5'h14, 8'h02);
        tick();
        chk_rd("lvl_ip", 5'h15, 8'h02);
        chk("lvl_irq", 16'(irq), 16'h1);
        wr(5'h15, 8'h02);
        chk_rd("lvl_ip_hold", 5'h15, 8'h02);
        tick();
        chk("lvl_irq_hold", 16'(irq), 16'h1);
        int_in[9] = 1'b0;
        tick(3);
        chk_rd("lvl_ip_sticky", 5'h15, 8'h02);
        wr(5'h15, 8'h02);
        chk_rd("lvl_ip_clr", 5'h15, 8'h00);
        tick();
        chk("lvl_irq_clr", 16'(irq), 16'h0);
        wr(5'h14, 8'h00);

        // Set/clear collision on channel 3
        wr(5'h12, 8'h09);
        int_in[3] = 1'b0;
        tick(2);
        wr(5'h11, 8'h08);
        chk_rd("coll_ip", 5'h11, 8'h08);
        wr(5'h11, 8'h08);
        chk_rd("coll_ip_clr", 5'h11, 8'h00);

        // Masking on channel 5 (level, active-low)
        int_in[5] = 1'b0;
        tick(3);
        chk_rd("mask_ip", 5'h11, 8'h20);
        chk("mask_irq", 16'(irq), 16'h0);
        wr(5'h10, 8'h20);
        chk("mask_irq_same", 16'(irq), 16'h0);
        tick();
        chk("mask_irq_en", 16'(irq), 16'h1);
        int_in[5] = 1'b1;
        tick(3);
        wr(5'h11, 8'h20);
        tick();
        chk("mask_irq_clr", 16'(irq), 16'h0);

        // Unimplemented bits and undecoded addresses
        wr(5'h14, 8'hFF);
        chk_rd("unused_bits", 5'h14, 8'h0F);
        wr(5'h14, 8'h00);
        wr(5'h18, 8'hFF);
        chk_rd("undec_wr_ie0", 5'h10, 8'h20);
        chk_rd("undec_wr_rd", 5'h18, 8'h00);

        // Arming: rising edges on pins held high through release are suppressed
        chk_rd2("arm_ip", 5'h01, 8'h00);
        int2 = 8'h00;
        tick(4);
        chk_rd2("arm_fall_ign", 5'h01, 8'h00);
        int2 = 8'hFF;
        tick(3);
        chk_rd2("arm_rise_ip", 5'h01, 8'hFF);
        wr2(5'h00, 8'hFF);
        tick();
        chk("arm_irq", 16'(irq2), 16'h1);

        // Asynchronous reset mid-cycle, no clock edge in between
        #2;
        rst2_n = 1'b0;
        #1;
        chk_rd2("async_ip", 5'h01, 8'h00);
        chk("async_irq", 16'(irq2), 16'h0);
        chk_rd2("async_ie", 5'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
